// File: rtl/multi_mode_round_robin_arbiter.sv
// N-way arbiter with runtime-selectable plain, prioritized and weighted round-robin modes.
// Grant is combinational from the requests and the registered ptr/credit/held/mode state.
module multi_mode_round_robin_arbiter #(
  parameter int REQUEST_WIDTH  = 8,
  parameter int PRIORITY_WIDTH = 2,
  parameter int WEIGHT_WIDTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [1:0]                               i_mode,
  input  logic [REQUEST_WIDTH*PRIORITY_WIDTH-1:0]  i_priority,
  input  logic [REQUEST_WIDTH*WEIGHT_WIDTH-1:0]    i_weight,
  input  logic [REQUEST_WIDTH-1:0]                 i_request,
  input  logic                                     i_lock,
  output logic [REQUEST_WIDTH-1:0]                 o_grant,
  output logic                                     o_grant_valid,
  output logic [$clog2(REQUEST_WIDTH)-1:0]         o_grant_index
);

  localparam int IW = $clog2(REQUEST_WIDTH);

  typedef enum logic [1:0] {
    MODE_PLAIN  = 2'd0,
    MODE_PRIO   = 2'd1,
    MODE_WEIGHT = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  mode_e                   mode_q;
  mode_e                   mode_in;
  mode_e                   mode_eff;
  logic [IW-1:0]           ptr;
  logic [WEIGHT_WIDTH-1:0] credit;
  logic                    held;

  logic                      mode_chg;
  logic [WEIGHT_WIDTH-1:0]   credit_eff;
  logic [PRIORITY_WIDTH-1:0] prio_arr [REQUEST_WIDTH];
  logic [WEIGHT_WIDTH-1:0]   weight_arr [REQUEST_WIDTH];
  logic [PRIORITY_WIDTH-1:0] max_pri;
  logic [REQUEST_WIDTH-1:0]  cand;
  logic [WEIGHT_WIDTH-1:0]   w_eff;
  logic                      req_ptr;
  logic                      lock_hit;
  logic                      stay;
  logic                      scan_hit;
  logic [IW-1:0]             scan_idx;
  logic                      gv;
  logic [IW-1:0]             gidx;

  always_comb begin
    mode_in  = mode_e'(i_mode);
    mode_chg = (mode_in != mode_q);
    mode_eff = (mode_in == MODE_RSVD) ? MODE_PLAIN : mode_in;
    credit_eff = mode_chg ? '0 : credit;

    for (int unsigned i = 0; i < REQUEST_WIDTH; i++) begin
      prio_arr[i]   = i_priority[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
      weight_arr[i] = i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    max_pri = '0;
    for (int unsigned i = 0; i < REQUEST_WIDTH; i++) begin
      if (i_request[i] && (prio_arr[i] > max_pri)) max_pri = prio_arr[i];
    end

    cand = i_request;
    if (mode_eff == MODE_PRIO) begin
      for (int unsigned i = 0; i < REQUEST_WIDTH; i++) begin
        cand[i] = i_request[i] && (prio_arr[i] == max_pri);
      end
    end

    // Scan ptr+1 .. ptr+N so that ptr itself is the last candidate considered.
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= REQUEST_WIDTH; k++) begin
      if (!scan_hit && cand[(32'(ptr) + k) % REQUEST_WIDTH]) begin
        scan_hit = 1'b1;
        scan_idx = IW'((32'(ptr) + k) % REQUEST_WIDTH);
      end
    end

    w_eff    = (weight_arr[ptr] == '0) ? WEIGHT_WIDTH'(1) : weight_arr[ptr];
    req_ptr  = i_request[ptr];
    lock_hit = held && !mode_chg && req_ptr;
    stay     = (mode_eff == MODE_WEIGHT) && req_ptr &&
               (credit_eff < (w_eff - WEIGHT_WIDTH'(1)));

    gv   = 1'b0;
    gidx = '0;
    if (rst_n) begin
      if (lock_hit || stay) begin
        gv   = 1'b1;
        gidx = ptr;
      end else if (scan_hit) begin
        gv   = 1'b1;
        gidx = scan_idx;
      end
    end

    o_grant       = gv ? (REQUEST_WIDTH'(1) << gidx) : '0;
    o_grant_valid = gv;
    o_grant_index = gidx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= IW'(REQUEST_WIDTH - 1);
      credit <= '0;
      held   <= 1'b0;
      mode_q <= MODE_PLAIN;
    end else begin
      mode_q <= mode_in;
      if (gv) ptr <= gidx;
      if (mode_chg) begin
        credit <= '0;
        held   <= 1'b0;
      end else begin
        held <= i_lock && gv;
        if (!gv) begin
          credit <= '0;
        end else if (!lock_hit) begin
          if (gidx == ptr) credit <= (credit == '1) ? credit : credit + WEIGHT_WIDTH'(1);
          else             credit <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_round_robin_arbiter.sv
// Directed bench for multi_mode_round_robin_arbiter (N=8, PRIORITY_WIDTH=2, WEIGHT_WIDTH=4).
// Inputs change 1ns after posedge; outputs are checked 3ns after posedge.
module tb_multi_mode_round_robin_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  i_mode;
  logic [15:0] i_priority;
  logic [31:0] i_weight;
  logic [7:0]  i_request;
  logic        i_lock;
  logic [7:0]  o_grant;
  logic        o_grant_valid;
  logic [2:0]  o_grant_index;

  int n_tests;
  int n_fail;

  multi_mode_round_robin_arbiter #(
    .REQUEST_WIDTH (8),
    .PRIORITY_WIDTH(2),
    .WEIGHT_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mode       (i_mode),
    .i_priority   (i_priority),
    .i_weight     (i_weight),
    .i_request    (i_request),
    .i_lock       (i_lock),
    .o_grant      (o_grant),
    .o_grant_valid(o_grant_valid),
    .o_grant_index(o_grant_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Checks all three outputs against an expected one-hot (or zero) grant, then advances one cycle.
  task automatic step(input string tag, input logic [7:0] exp_grant);
    logic [2:0] exp_idx;
    exp_idx = '0;
    for (int i = 0; i < 8; i++) if (exp_grant[i]) exp_idx = 3'(i);
    #2;
    check({tag, ".grant"}, 32'(o_grant), 32'(exp_grant));
    check({tag, ".valid"}, 32'(o_grant_valid), 32'(exp_grant != 8'h00));
    check({tag, ".index"}, 32'(o_grant_index), 32'(exp_idx));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst.grant", 32'(o_grant), 32'h0);
    check("rst.valid", 32'(o_grant_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] seq1 [9];
  logic [7:0] seq3 [6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    i_mode = 2'd0;
    i_priority = '0;
    i_weight = '0;
    i_request = 8'hFF;
    i_lock = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: plain RR over all requesters
    seq1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    for (int i = 0; i < 9; i++) step("plain", seq1[i]);

    // 2: prioritized RR, priority[i]=i%4, only indices 3 and 7 at the top level
    i_mode = 2'd1;
    i_priority = 16'hE4E4;
    step("prio0", 8'h08);
    step("prio1", 8'h80);
    step("prio2", 8'h08);
    step("prio3", 8'h80);

    // 3: weighted RR, weight[i]=i+1
    i_mode = 2'd2;
    i_weight = 32'h8765_4321;
    i_request = 8'h03;
    seq3 = '{8'h01, 8'h02, 8'h02, 8'h01, 8'h02, 8'h02};
    for (int i = 0; i < 6; i++) step("wrr", seq3[i]);
    i_weight = 32'h8765_4320;
    step("wrr_w0a", 8'h01);
    step("wrr_w0b", 8'h02);

    // 4: lock holds grant 0 across cycles 0..3
    i_mode = 2'd0;
    i_weight = '0;
    i_request = 8'h05;
    do_reset();
    i_lock = 1'b1;
    step("lock0", 8'h01);
    step("lock1", 8'h01);
    step("lock2", 8'h01);
    i_lock = 1'b0;
    step("lock3", 8'h01);
    step("lock4", 8'h04);
    do_reset();
    i_lock = 1'b1;
    step("lockv0", 8'h01);
    step("lockv1", 8'h01);
    i_request = 8'h04;
    step("lockv2", 8'h04);
    i_lock = 1'b0;

    // 5: weighted burst interrupted by reset
    do_reset();
    i_mode = 2'd2;
    i_weight = 32'h0000_0008;
    i_request = 8'h01;
    step("wb0", 8'h01);
    step("wb1", 8'h01);
    step("wb2", 8'h01);
    do_reset();
    i_request = 8'h03;
    for (int i = 0; i < 8; i++) step("wbr", 8'h01);
    step("wbr_rot", 8'h02);

    // 6: mode change drops lock; idle cycle keeps ptr
    i_mode = 2'd0;
    i_weight = '0;
    i_request = 8'h0F;
    do_reset();
    step("mc0", 8'h01);
    i_mode = 2'd2;
    i_lock = 1'b1;
    step("mc1", 8'h02);
    step("mc2", 8'h04);
    i_request = 8'h00;
    step("idle", 8'h00);
    i_request = 8'h0F;
    i_lock = 1'b0;
    step("mc3", 8'h08);
    i_mode = 2'd3;
    step("rsvd", 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
